// File: rtl/text_renderer.sv
// text_renderer
//   Text-mode scanline renderer. For each scanline it reads character codes
//   from the character RAM, forms font ROM addresses from them, and shifts
//   the returned glyph bytes out as a 1-bit pixel stream, one pixel per clk.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for an accepted lineStart
//   FETCH | issuing one character address every 8 cycles (COLS*8 cycles)
//   DRAIN | 3 cycles letting the last glyph shift out
//
// Ports
//   clk, rst        system clock; synchronous active-high reset
//   frameStart      pulse: restart at text row 0, glyph row 0
//   lineStart       pulse: render the next scanline (aborts a line in flight)
//   charRdAddr      character RAM read address (registered)
//   charRdData      character code, 1 cycle after charRdAddr
//   fontRdAddr      {charCode, glyphRow}, meaningful the cycle after issue
//   fontRdData      glyph byte, 1 cycle after fontRdAddr, bit 7 leftmost
//   pixelOn         current pixel (registered)
//   pixelValid      pixelOn belongs to the active region (registered)
//   busy            line fetch or drain in progress (registered)
module text_renderer #(
  parameter int COLS        = 80,
  parameter int ROWS        = 30,
  parameter int CHAR_ADDR_W = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frameStart,
  input  logic                   lineStart,
  output logic [CHAR_ADDR_W-1:0] charRdAddr,
  input  logic [7:0]             charRdData,
  output logic [11:0]            fontRdAddr,
  input  logic [7:0]             fontRdData,
  output logic                   pixelOn,
  output logic                   pixelValid,
  output logic                   busy
);

  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [COL_W-1:0]       LAST_COL      = COL_W'(COLS - 1);
  localparam logic [CHAR_ADDR_W-1:0] COLS_STEP     = CHAR_ADDR_W'(COLS);
  localparam logic [CHAR_ADDR_W-1:0] LAST_ROW_BASE = CHAR_ADDR_W'((ROWS - 1) * COLS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, next_state;

  logic [3:0]             glyph_row;
  logic [CHAR_ADDR_W-1:0] row_base;
  logic                   frame_done;
  logic [COL_W-1:0]       col;
  logic [2:0]             sub;
  logic [1:0]             drain_cnt;
  logic [CHAR_ADDR_W-1:0] char_addr;
  logic                   stage1_vld;
  logic                   stage2_vld;
  logic [7:0]             shift_reg;
  logic [2:0]             pix_cnt;
  logic                   pix_valid;
  logic                   busy_q;

  logic line_go;
  logic last_fetch;
  logic issue;

  // A frameStart in the same cycle clears frame_done first, so the line
  // still goes ahead.
  assign line_go    = lineStart && (frameStart || !frame_done);
  assign last_fetch = (state == FETCH) && (col == LAST_COL) && (sub == 3'd7);
  assign issue      = (state == FETCH) && (sub == 3'd0);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (line_go) next_state = FETCH;
      end
      FETCH: begin
        if (line_go)         next_state = FETCH;
        else if (last_fetch) next_state = DRAIN;
      end
      DRAIN: begin
        if (line_go)                next_state = FETCH;
        else if (drain_cnt == 2'd2) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Frame position. An aborted line never reaches last_fetch, so it does not
  // advance. The final text row sets frame_done instead of stepping rowBase
  // past the last row.
  always_ff @(posedge clk) begin
    if (rst) begin
      glyph_row  <= '0;
      row_base   <= '0;
      frame_done <= 1'b0;
    end else if (frameStart) begin
      glyph_row  <= '0;
      row_base   <= '0;
      frame_done <= 1'b0;
    end else if (last_fetch && !line_go) begin
      glyph_row <= glyph_row + 4'd1;
      if (glyph_row == 4'd15) begin
        if (row_base == LAST_ROW_BASE) frame_done <= 1'b1;
        else                           row_base   <= row_base + COLS_STEP;
      end
    end
  end

  // Column/sub-pixel counters. char_addr is loaded one cycle ahead so that
  // it is already on charRdAddr during the sub==0 cycle of each character.
  always_ff @(posedge clk) begin
    if (rst) begin
      col       <= '0;
      sub       <= '0;
      drain_cnt <= '0;
      char_addr <= '0;
    end else if (line_go) begin
      col       <= '0;
      sub       <= '0;
      drain_cnt <= '0;
      char_addr <= frameStart ? '0 : row_base;
    end else begin
      case (state)
        FETCH: begin
          sub <= sub + 3'd1;
          if (sub == 3'd7 && col != LAST_COL) begin
            col       <= col + COL_W'(1);
            char_addr <= char_addr + CHAR_ADDR_W'(1);
          end
          drain_cnt <= '0;
        end
        DRAIN:   drain_cnt <= drain_cnt + 2'd1;
        default: drain_cnt <= '0;
      endcase
    end
  end

  // Read pipeline: issue -> char data (stage1) -> glyph data (stage2) ->
  // shift register. The next glyph loads on the same edge that the previous
  // one finishes, so pixels run without gaps.
  always_ff @(posedge clk) begin
    if (rst || line_go) begin
      stage1_vld <= 1'b0;
      stage2_vld <= 1'b0;
      shift_reg  <= '0;
      pix_cnt    <= '0;
      pix_valid  <= 1'b0;
    end else begin
      stage1_vld <= issue;
      stage2_vld <= stage1_vld;
      if (stage2_vld) begin
        shift_reg <= fontRdData;
        pix_cnt   <= 3'd7;
        pix_valid <= 1'b1;
      end else if (pix_valid) begin
        shift_reg <= {shift_reg[6:0], 1'b0};
        pix_cnt   <= pix_cnt - 3'd1;
        if (pix_cnt == 3'd0) pix_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= 1'b0;
    else     busy_q <= (next_state != IDLE);
  end

  // After eight shifts the register is empty, so pixelOn is 0 outside the
  // active region without extra gating.
  assign charRdAddr = char_addr;
  assign fontRdAddr = {charRdData, glyph_row};
  assign pixelOn    = shift_reg[7];
  assign pixelValid = pix_valid;
  assign busy       = busy_q;

endmodule

// File: tb/tb_text_renderer.sv
// Bench for text_renderer. Character RAM and font ROM are modelled as
// registered memories filled with random contents; expected pixels are
// computed directly from memory contents, text row and glyph row.
module tb_text_renderer;

  localparam int COLS = 80;
  localparam int ROWS = 2;
  localparam int AW   = 12;
  localparam int LINE_PIX = COLS * 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          frameStart;
  logic          lineStart;
  logic [AW-1:0] charRdAddr;
  logic [7:0]    charRdData;
  logic [11:0]   fontRdAddr;
  logic [7:0]    fontRdData;
  logic          pixelOn;
  logic          pixelValid;
  logic          busy;

  logic [7:0] char_mem [0:4095];
  logic [7:0] font_mem [0:4095];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  text_renderer #(.COLS(COLS), .ROWS(ROWS), .CHAR_ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .frameStart (frameStart),
    .lineStart  (lineStart),
    .charRdAddr (charRdAddr),
    .charRdData (charRdData),
    .fontRdAddr (fontRdAddr),
    .fontRdData (fontRdData),
    .pixelOn    (pixelOn),
    .pixelValid (pixelValid),
    .busy       (busy)
  );

  always @(posedge clk) begin
    charRdData <= char_mem[charRdAddr];
    fontRdData <= font_mem[fontRdAddr];
  end

  // Caller is at a negedge with the DUT idle (or mid-line for an abort);
  // that negedge is cycle 0 of the new line.
  task automatic run_line(input int row, input int glyph, input bit with_fs);
    int perr, berr, nvalid, k, first_bad;
    logic [7:0] code, bits;
    logic [11:0] exp_font;
    logic ev, eo, eb;
    perr = 0; berr = 0; nvalid = 0; first_bad = -1;
    lineStart  = 1'b1;
    frameStart = with_fs;
    @(negedge clk);
    lineStart  = 1'b0;
    frameStart = 1'b0;
    for (int c = 1; c <= LINE_PIX + 6; c++) begin
      if (c == 1) begin
        checks++;
        if (charRdAddr !== AW'(row * COLS)) begin
          failures++;
          $display("FAIL first_char_addr row=%0d glyph=%0d actual=%0d expected=%0d",
                   row, glyph, charRdAddr, row * COLS);
        end
      end
      if (c == 2) begin
        exp_font = {char_mem[row * COLS], 4'(glyph)};
        checks++;
        if (fontRdAddr !== exp_font) begin
          failures++;
          $display("FAIL font_addr row=%0d glyph=%0d actual=%h expected=%h",
                   row, glyph, fontRdAddr, exp_font);
        end
      end
      ev = (c >= 4) && (c <= 3 + LINE_PIX);
      eo = 1'b0;
      if (ev) begin
        k    = c - 4;
        code = char_mem[row * COLS + k / 8];
        bits = font_mem[{code, 4'(glyph)}];
        eo   = bits[7 - (k % 8)];
      end
      eb = (c <= 3 + LINE_PIX);
      if (pixelValid === 1'b1) nvalid++;
      if (pixelValid !== ev || pixelOn !== eo) begin
        perr++;
        if (first_bad < 0) first_bad = c;
      end
      if (busy !== eb) berr++;
      @(negedge clk);
    end
    checks++;
    if (perr != 0) begin
      failures++;
      $display("FAIL pixels row=%0d glyph=%0d bad_cycles=%0d first_bad_cycle=%0d expected_bad=0",
               row, glyph, perr, first_bad);
    end
    checks++;
    if (nvalid != LINE_PIX) begin
      failures++;
      $display("FAIL valid_count row=%0d glyph=%0d actual=%0d expected=%0d",
               row, glyph, nvalid, LINE_PIX);
    end
    checks++;
    if (berr != 0) begin
      failures++;
      $display("FAIL busy_window row=%0d glyph=%0d bad_cycles=%0d expected=0", row, glyph, berr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; frameStart = 1'b0; lineStart = 1'b0;
    for (int i = 0; i < 2; i++) begin
      lineStart = ~lineStart;
      @(negedge clk);
      checks++;
      if (pixelValid !== 1'b0 || pixelOn !== 1'b0 || busy !== 1'b0 || charRdAddr !== '0) begin
        failures++;
        $display("FAIL reset_state cycle=%0d actual=v%b p%b b%b a%0d expected=v0 p0 b0 a0",
                 i, pixelValid, pixelOn, busy, charRdAddr);
      end
    end
    lineStart = 1'b0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_first_line();
    frameStart = 1'b1;
    @(negedge clk);
    frameStart = 1'b0;
    run_line(0, 0, 1'b0);
  endtask

  task automatic test_frame_end();
    int berr;
    logic [AW-1:0] last_addr;
    for (int ln = 1; ln < ROWS * 16; ln++) run_line(ln / 16, ln % 16, 1'b0);
    last_addr = AW'(ROWS * COLS - 1);
    berr = 0;
    lineStart = 1'b1;
    @(negedge clk);
    lineStart = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (busy !== 1'b0 || pixelValid !== 1'b0 || pixelOn !== 1'b0 || charRdAddr !== last_addr) berr++;
      @(negedge clk);
    end
    checks++;
    if (berr != 0) begin
      failures++;
      $display("FAIL frame_done_ignore bad_cycles=%0d expected=0 addr=%0d expected_addr=%0d",
               berr, charRdAddr, last_addr);
    end
    run_line(0, 0, 1'b1);
  endtask

  // Abort at cycle `at`; the restarted line must keep the same glyph row.
  task automatic test_abort(input int at, input int glyph);
    lineStart = 1'b1;
    @(negedge clk);
    lineStart = 1'b0;
    for (int c = 1; c < at; c++) @(negedge clk);
    checks++;
    if (pixelValid !== 1'b1) begin
      failures++;
      $display("FAIL abort_pre_valid at=%0d actual=%b expected=1", at, pixelValid);
    end
    run_line(0, glyph, 1'b0);
  endtask

  task automatic test_reset_midline();
    int berr;
    lineStart = 1'b1;
    @(negedge clk);
    lineStart = 1'b0;
    for (int c = 1; c < 50; c++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    berr = 0;
    for (int c = 51; c < 60; c++) begin
      if (pixelValid !== 1'b0 || pixelOn !== 1'b0 || busy !== 1'b0 || charRdAddr !== '0) berr++;
      @(negedge clk);
    end
    checks++;
    if (berr != 0) begin
      failures++;
      $display("FAIL reset_midline bad_cycles=%0d expected=0", berr);
    end
    run_line(0, 0, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4096; i++) begin
      char_mem[i] = 8'($urandom);
      font_mem[i] = 8'($urandom);
    end
    char_mem[0]     = 8'h41;
    font_mem[12'h410] = 8'b1000_0001;
    rst = 1'b1; frameStart = 1'b0; lineStart = 1'b0;

    test_reset();
    test_first_line();
    test_frame_end();
    test_abort(100, 1);
    test_abort(int'($urandom_range(5, 600)), 2);
    run_line(0, 3, 1'b0);
    test_reset_midline();
    run_line(0, 1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/text_renderer.md
Name: text_renderer

Overview:
- Text-mode scanline renderer; the read-side client of the font ROM and the character RAM.
- Per scanline it fetches character codes, forms font ROM addresses, and receives glyph bytes with 1-cycle registered latency.
- It serialises the glyph bytes into a 1-bit pixel stream for the VGA output stage.
- One pixel per clk; the VGA timing generator supplies frameStart and lineStart pulses.

Parameters:
- COLS, 80, characters per text row (pixels per line = COLS*8).
- ROWS, 30, text rows per frame (scanlines rendered = ROWS*16).
- CHAR_ADDR_W, 12, character RAM address width; must satisfy COLS*ROWS <= 2^CHAR_ADDR_W.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- frameStart  in  1  one-cycle pulse: new frame begins.
- lineStart  in  1  one-cycle pulse: begin rendering the next scanline.
- charRdAddr  out  CHAR_ADDR_W  character RAM read address.
- charRdData  in  8  character code; registered RAM, valid 1 cycle after charRdAddr.
- fontRdAddr  out  12  font ROM address = {charCode[7:0], glyphRow[3:0]}.
- fontRdData  in  8  glyph byte; valid 1 cycle after fontRdAddr; bit 7 is the leftmost pixel.
- pixelOn  out  1  current pixel (1 = foreground).
- pixelValid  out  1  pixelOn is an active-region pixel this cycle.
- busy  out  1  a line fetch or drain is in progress.

Behaviour:
- Reset: all registers clear. pixelOn=0, pixelValid=0, busy=0, charRdAddr=0. glyphRow=0, rowBase=0, state IDLE.
- Frame state:
  - glyphRow (0..15) and rowBase (character RAM address of the current text row) are held in registers.
  - rowBase advances by an adder only, never a multiplier.
- frameStart: glyphRow<=0, rowBase<=0, frameDone<=0. If lineStart arrives in the same cycle, the frame reset applies first and the line renders text row 0, glyph row 0.
- lineStart while frameDone=1: ignored; outputs stay idle.
- States:
  - IDLE: waits for lineStart, then goes to FETCH with col=0, sub=0.
  - FETCH: sub counts 0..7 each cycle and col counts 0..COLS-1.
    - When sub==0, charRdAddr <= rowBase+col.
    - At col==COLS-1, sub==7, go to DRAIN.
  - DRAIN: lasts 3 cycles, then returns to IDLE.
- Pipeline, with the character issued at cycle t (sub==0):
  - t+1: fontRdAddr = {charRdData, glyphRow}. This may be combinational from charRdData; it is only meaningful in this cycle.
  - t+2: fontRdData valid; the 8-bit shift register loads at the end of t+2.
  - t+3..t+10: pixelOn = shiftReg[7], shifting left each cycle.
- Characters issue every 8 cycles, so the stream is gap-free.
- Latency: if lineStart is sampled at cycle 0, the first charRdAddr is driven in cycle 1.
  - pixelValid=1 exactly in cycles 4..3+COLS*8; pixelOn, pixelValid and busy are registered.
  - busy=1 from cycle 1 until the last valid pixel, inclusive.
- Outside active pixels: pixelValid=0 and pixelOn=0.
- End of line: on the last FETCH cycle, glyphRow increments.
  - On wrap 15->0, rowBase <= rowBase+COLS.
  - If that wrap completes text row ROWS-1, set frameDone=1. rowBase must never be used past ROWS*COLS-1.
- lineStart during FETCH/DRAIN (early pulse): abort the current line.
  - pixelValid drops the next cycle.
  - The pipeline is flushed and glyphRow/rowBase are not advanced.
  - Restart a fresh line with the same cycle-0 timing as above.
- rst mid-line: immediate return to reset values on the next edge; no partial pixels emitted afterwards.

Test Plan:
1. Reset check: assert rst for 2 cycles with lineStart toggling -> pixelValid=0, pixelOn=0, busy=0, charRdAddr=0 throughout.
2. First line: frameStart, then lineStart at cycle 0, char RAM[0]=0x41, font[0x410]=0b10000001.
   - charRdAddr=0 in cycle 1 and fontRdAddr=0x410 in cycle 2.
   - pixelValid rises in cycle 4; pixels in cycles 4..11 = 1,0,0,0,0,0,0,1.
   - 640 valid cycles total, with no gaps.
3. Glyph row advance: issue 16 lineStarts (each after busy falls).
   - Line 2 issues fontRdAddr {code,4'h1}.
   - Line 17 issues charRdAddr=80 first (rowBase advanced).
4. Frame end: 480 lines, then a further lineStart -> no charRdAddr activity, busy stays 0. A following frameStart+lineStart in the same cycle -> charRdAddr=0, glyph row 0.
5. Abort: a second lineStart at cycle 100 of a line -> pixelValid=0 in cycle 101, a new first valid pixel in cycle 104, and glyphRow unchanged.
6. Reset mid-line: rst at cycle 50 -> all outputs 0 from cycle 51. The next frameStart/lineStart renders text row 0 normally.
